// File: rtl/ps2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_pkg: scancodes, key-to-duty map and decoder state type        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_KEY_A = 8'h2B;
  localparam logic [7:0] SC_KEY_B = 8'h15;
  localparam logic [7:0] SC_KEY_C = 8'h33;
  localparam logic [7:0] SC_KEY_D = 8'h22;

  localparam logic [8:0] DUTY_A = 9'd20;
  localparam logic [8:0] DUTY_B = 9'd25;
  localparam logic [8:0] DUTY_C = 9'd30;
  localparam logic [8:0] DUTY_D = 9'd40;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [8:0] val;
  } key_map_t;

  function automatic key_map_t key_map(input logic [7:0] code);
    key_map_t m;
    m = '0;
    case (code)
      SC_KEY_A: m = '{hit: 1'b1, val: DUTY_A};
      SC_KEY_B: m = '{hit: 1'b1, val: DUTY_B};
      SC_KEY_C: m = '{hit: 1'b1, val: DUTY_C};
      SC_KEY_D: m = '{hit: 1'b1, val: DUTY_D};
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tone_pwm_pwm_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_core: prescaler, period counter, shadow duty and compare      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pwm_core #(
  parameter int CLK_DIV = 25,
  parameter int PERIOD  = 400,
  parameter int CNT_W   = $clog2(PERIOD + 1)
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic [CNT_W-1:0] pending,
  output logic             pwm,
  output logic [CNT_W-1:0] duty,
  output logic             period_end
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);

  logic             w_tick;
  logic             w_last;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_duty;
  logic             r_pwm;

  if (CLK_DIV == 1) begin : g_no_div
    assign w_tick = 1'b1;
  end else begin : g_div
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(CLK_DIV - 1);
    logic [PRE_W-1:0] r_pre_cnt;

    always_ff @(posedge pixclk) begin
      if (reset) begin
        r_pre_cnt <= '0;
      end else if (r_pre_cnt == C_PRE_LAST) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
      end
    end

    assign w_tick = (r_pre_cnt == C_PRE_LAST);
  end

  assign w_last = (r_cnt == C_LAST);

  // Duty is only sampled from pending at the period boundary to keep pulses whole.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (w_tick) begin
        if (w_last) begin
          r_cnt  <= '0;
          r_duty <= pending;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end
      r_pwm <= (r_cnt < r_duty);
    end
  end

  assign pwm        = r_pwm;
  assign duty       = r_duty;
  assign period_end = w_tick & w_last;

endmodule
`default_nettype wire

// File: rtl/ps2_tone_pwm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_tone_pwm: PS/2 scancode decoder selecting a PWM duty          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ps2_tone_pwm
  import ps2_pkg::*;
#(
  parameter  int CLK_DIV = 25,
  parameter  int PERIOD  = 400,
  localparam int CNT_W   = $clog2(PERIOD + 1)
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             scan_valid,
  input  logic [7:0]       scancode,
  output logic             pwm,
  output logic             active,
  output logic [CNT_W-1:0] duty,
  output logic             period_end
);

  localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(PERIOD);

  dec_state_t       r_state;
  dec_state_t       w_state_next;
  logic [7:0]       r_held_code;
  logic [7:0]       w_held_next;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_next;
  logic             r_active;
  logic             w_active_next;
  key_map_t         w_map;
  logic [CNT_W-1:0] w_map_sat;

  assign w_map     = key_map(scancode);
  assign w_map_sat = (int'(w_map.val) >= PERIOD) ? C_PERIOD : CNT_W'(w_map.val);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_held_code <= '0;
      r_pending   <= '0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_held_code <= w_held_next;
      r_pending   <= w_pending_next;
      r_active    <= w_active_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scancode == SC_BREAK) begin
            w_state_next = ST_BREAK;
          end else if (scancode == SC_EXT) begin
            w_state_next = ST_EXT;
          end
        end
        ST_EXT:   w_state_next = (scancode == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Extended sequences never reach this logic, so E0-prefixed keys leave duty alone.
  always_comb begin
    w_held_next    = r_held_code;
    w_pending_next = r_pending;
    w_active_next  = r_active;
    if (scan_valid) begin
      if (r_state == ST_IDLE && w_map.hit && scancode != r_held_code) begin
        w_held_next    = scancode;
        w_pending_next = w_map_sat;
        w_active_next  = 1'b1;
      end else if (r_state == ST_BREAK && scancode == r_held_code) begin
        w_held_next    = '0;
        w_pending_next = '0;
        w_active_next  = 1'b0;
      end
    end
  end

  assign active = r_active;

  pwm_core #(
    .CLK_DIV (CLK_DIV),
    .PERIOD  (PERIOD),
    .CNT_W   (CNT_W)
  ) u_pwm_core (
    .pixclk     (pixclk),
    .reset      (reset),
    .pending    (r_pending),
    .pwm        (pwm),
    .duty       (duty),
    .period_end (period_end)
  );

endmodule
`default_nettype wire

// File: tb/tb_ps2_tone_pwm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ps2_tone_pwm: directed checks of decoder, shadow load and PWM  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ps2_tone_pwm;

  logic       pixclk = 1'b0;
  logic       reset  = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scancode   = 8'h00;

  logic       pwm, active, period_end;
  logic [5:0] duty;
  logic       pwm2, active2, period_end2;
  logic [4:0] duty2;

  int checks = 0;
  int errors = 0;

  always #5 pixclk = ~pixclk;

  ps2_tone_pwm #(.CLK_DIV(2), .PERIOD(50)) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scancode   (scancode),
    .pwm        (pwm),
    .active     (active),
    .duty       (duty),
    .period_end (period_end)
  );

  ps2_tone_pwm #(.CLK_DIV(2), .PERIOD(30)) dut_sat (
    .pixclk     (pixclk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scancode   (scancode),
    .pwm        (pwm2),
    .active     (active2),
    .duty       (duty2),
    .period_end (period_end2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge pixclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scancode   = b;
    @(posedge pixclk);
    #1;
    scan_valid = 1'b0;
  endtask

  // Returns at the negedge of a period_end cycle; the next posedge is the shadow load.
  task automatic wait_pe(input bit sat, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pixclk);
      if ((sat ? period_end2 : period_end) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  initial begin
    int n;
    int hi;

    repeat (2) @(posedge pixclk);
    #1;
    reset = 1'b0;

    // Leave the decoder mid-sequence (in BREAK) before resetting.
    send(8'h2B);
    check("pre_active", active, 1);
    send(8'hF0);
    repeat (37) step;

    reset = 1'b1;
    step;
    check("rst_pwm", pwm, 0);
    check("rst_active", active, 0);
    check("rst_duty", duty, 0);
    check("rst_pe", period_end, 0);
    repeat (2) step;
    reset = 1'b0;

    n = 0;
    while (n < 200) begin
      @(negedge pixclk);
      if (period_end) break;
      n++;
    end
    check("first_pe_cycle", n, 99);
    step;

    // Make 2B: the partial break before reset must not swallow it.
    send(8'h2B);
    check("make_active", active, 1);
    check("make_duty_hold", duty, 0);
    wait_pe(1'b0, "pe_make");
    check("duty_before_load", duty, 0);
    step;
    check("duty_20", duty, 20);
    check("pwm_lag", pwm, 0);
    hi = 0;
    step;
    check("pwm_rise", pwm, 1);
    hi += int'(pwm);
    for (int i = 3; i <= 100; i++) begin
      step;
      hi += int'(pwm);
    end
    check("period_len", period_end, 1);
    check("pwm_high_40", hi, 40);

    // Last key wins, break of a non-held key is ignored.
    send(8'h15);
    send(8'h22);
    check("lastkey_active", active, 1);
    wait_pe(1'b0, "pe_lastkey");
    step;
    check("duty_40", duty, 40);
    send(8'hF0);
    send(8'h15);
    check("break_other_active", active, 1);
    wait_pe(1'b0, "pe_break_other");
    step;
    check("break_other_duty", duty, 40);
    send(8'hF0);
    send(8'h22);
    check("break_held_active", active, 0);
    check("break_duty_hold", duty, 40);
    wait_pe(1'b0, "pe_break");
    step;
    check("break_duty_0", duty, 0);

    // Extended make/break and an unmapped key, back to back.
    send(8'hE0);
    send(8'h2B);
    send(8'hE0);
    send(8'hF0);
    send(8'h2B);
    send(8'h1C);
    check("ext_active", active, 0);
    wait_pe(1'b0, "pe_ext");
    step;
    check("ext_duty", duty, 0);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step;
      hi += int'(pwm);
    end
    check("pwm_zero", hi, 0);

    // Byte arriving exactly on the period_end cycle.
    wait_pe(1'b0, "pe_coinc");
    scan_valid = 1'b1;
    scancode   = 8'h33;
    @(posedge pixclk);
    #1;
    scan_valid = 1'b0;
    check("coinc_active", active, 1);
    check("coinc_old_duty", duty, 0);
    wait_pe(1'b0, "pe_coinc_next");
    check("coinc_still_old", duty, 0);
    step;
    check("coinc_duty_30", duty, 30);

    // Saturation on the PERIOD=30 instance.
    send(8'hF0);
    send(8'h33);
    check("sat_clear_active", active2, 0);
    wait_pe(1'b1, "pe_sat_clear");
    step;
    check("sat_duty_0", duty2, 0);
    send(8'h22);
    check("sat_active", active2, 1);
    wait_pe(1'b1, "pe_sat");
    step;
    check("sat_duty_30", duty2, 30);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      step;
      hi += int'(pwm2);
    end
    check("sat_pwm_full", hi, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
